// File: rtl/ab_pair_gen.sv
// rtl/ab_pair_gen.sv - LFSR-driven burst generator of (a, b) pairs constrained to a&b, a|b or a^b.
// Supports one-shot violation injection so downstream property checkers can be shown to fire.
module ab_pair_gen #(
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED   = 16'hACE1,
  parameter int                CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_pairs,
  input  logic [1:0]       mode,
  input  logic             inject_err,
  output logic             a,
  output logic             b,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pair_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [LFSR_W-1:0] TAPS      = LFSR_W'(16'hB400);
  localparam logic [LFSR_W-1:0] SEED_SAFE = (SEED == '0) ? LFSR_W'(1) : SEED;

  state_t             state_q, state_d;
  logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
  logic               err_pend_q, err_pend_d;
  logic               a_q, a_d;
  logic               b_q, b_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic [1:0]         mode_q, mode_d;
  logic               emit;
  logic [1:0]         pair_mode;
  logic               ra, rb;

  assign ra = lfsr_q[0];
  assign rb = lfsr_q[1];

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    err_pend_d = err_pend_q;
    a_d        = a_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    n_d        = n_q;
    mode_d     = mode_q;
    emit       = 1'b0;
    pair_mode  = mode_q;

    // The first pair is emitted on the accepting edge, so it must use the live mode input.
    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d    = num_pairs;
          mode_d = mode;
          cnt_d  = '0;
          if (num_pairs == '0) begin
            state_d = S_DONE;
          end else begin
            emit      = 1'b1;
            pair_mode = mode;
            state_d   = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (cnt_q == n_q) begin
          state_d = S_DONE;
        end else begin
          emit = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (emit) begin
      lfsr_d = (lfsr_q >> 1) ^ (ra ? TAPS : '0);
      cnt_d  = cnt_d + CNT_W'(1);
      case (pair_mode)
        2'd1: begin
          a_d = err_pend_q ? 1'b0 : 1'b1;
          b_d = err_pend_q ? rb   : 1'b1;
        end
        2'd2: begin
          a_d = err_pend_q ? 1'b0 : (ra | ~rb);
          b_d = err_pend_q ? 1'b0 : rb;
        end
        2'd3: begin
          a_d = ra;
          b_d = err_pend_q ? ra : ~ra;
        end
        default: begin
          a_d = ra;
          b_d = rb;
        end
      endcase
    end

    // A request arriving on an emitting edge survives the consumption and hits the next pair.
    err_pend_d = (err_pend_q & ~emit) | inject_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      lfsr_q     <= SEED_SAFE;
      err_pend_q <= 1'b0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      cnt_q      <= '0;
      n_q        <= '0;
      mode_q     <= 2'd0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      err_pend_q <= err_pend_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      mode_q     <= mode_d;
    end
  end

  assign a        = a_q;
  assign b        = b_q;
  assign valid    = (state_q == S_RUN);
  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign pair_cnt = cnt_q;

endmodule

// File: tb/tb_ab_pair_gen.sv
// tb/tb_ab_pair_gen.sv - randomized bench for ab_pair_gen against a pair-index reference model.
module tb_ab_pair_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] num_pairs = 8'd0;
  logic [1:0] mode = 2'd0;
  logic       inject_err = 1'b0;
  logic       a, b, valid, busy, done;
  logic [7:0] pair_cnt;

  int errors = 0;
  int checks = 0;

  ab_pair_gen dut (
    .clk(clk), .rst(rst), .start(start), .num_pairs(num_pairs), .mode(mode),
    .inject_err(inject_err), .a(a), .b(b), .valid(valid), .busy(busy),
    .done(done), .pair_cnt(pair_cnt)
  );

  always #5 clk = ~clk;

  // Reference: the k-th pair since reset draws its raw bits from lfsr_seq[k].
  logic [15:0] lfsr_seq [0:4095];
  initial begin
    lfsr_seq[0] = 16'hACE1;
    for (int i = 1; i < 4096; i++)
      lfsr_seq[i] = (lfsr_seq[i-1] >> 1) ^ (lfsr_seq[i-1][0] ? 16'hB400 : 16'h0000);
  end

  function automatic logic [1:0] model_pair(input int md, input logic ra, input logic rb,
                                            input logic corrupt);
    case (md)
      1:       return corrupt ? {1'b0, rb} : 2'b11;
      2:       return corrupt ? 2'b00 : {ra | ~rb, rb};
      3:       return corrupt ? {ra, ra} : {ra, ~ra};
      default: return {ra, rb};
    endcase
  endfunction

  bit   m_init = 0;
  bit   m_valid, m_done, m_pend, m_emit;
  logic m_a, m_b;
  int   m_cnt, m_n, m_mode, m_idx;

  always @(posedge clk) begin
    m_init = 1;
    if (rst) begin
      m_valid = 0; m_done = 0; m_pend = 0;
      m_a = 0; m_b = 0; m_cnt = 0; m_n = 0; m_mode = 0; m_idx = 0;
    end else begin
      m_emit = 0;
      if (m_valid) begin
        if (m_cnt == m_n) begin
          m_valid = 0; m_done = 1;
        end else m_emit = 1;
      end else if (m_done) begin
        m_done = 0;
      end else if (start) begin
        m_n = int'(num_pairs); m_mode = int'(mode); m_cnt = 0;
        if (num_pairs == 8'd0) m_done = 1;
        else begin
          m_emit = 1; m_valid = 1;
        end
      end
      if (m_emit) begin
        {m_a, m_b} = model_pair(m_mode, lfsr_seq[m_idx][0], lfsr_seq[m_idx][1], m_pend);
        m_idx++;
        m_cnt++;
      end
      m_pend = (m_pend && !m_emit) || inject_err;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      logic [12:0] got, expv;
      got  = {a, b, valid, busy, done, pair_cnt};
      expv = {m_a, m_b, m_valid, m_valid, m_done, 8'(m_cnt)};
      checks++;
      if (got !== expv) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t got {a,b,valid,busy,done,cnt}=%h required=%h", $time, got, expv);
      end
    end
  end

  task automatic chk(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, got, expv);
    end
  endtask

  task automatic run_burst(input int n, input int m, input int inj_at, input int start_at,
                           input int rst_at, output int vcnt, output int eqcnt, output int eqpos,
                           output int donec, output int viol, output int fa, output int fb,
                           output int lastcnt);
    vcnt = 0; eqcnt = 0; eqpos = 0; donec = 0; viol = 0; fa = -1; fb = -1; lastcnt = -1;
    start = 1; num_pairs = 8'(n); mode = 2'(m);
    for (int c = 1; c <= n + 3; c++) begin
      @(posedge clk); #1;
      start = (c == start_at);
      if (c == start_at) num_pairs = 8'(n + 5);
      inject_err = (c == inj_at);
      rst = (c == rst_at);
      @(negedge clk);
      if (valid === 1'b1) begin
        vcnt++;
        if (fa < 0) begin fa = int'(a); fb = int'(b); end
        if (a == b) begin eqcnt++; eqpos = c; end
        if ((m == 1 && !(a & b)) || (m == 2 && !(a | b)) || (m == 3 && !(a ^ b))) viol++;
      end
      if (done === 1'b1) begin donec = c; lastcnt = int'(pair_cnt); end
    end
    @(posedge clk); #1;
    start = 0; inject_err = 0; rst = 0;
  endtask

  initial begin
    int vc, eqc, eqp, dc, vi, fa, fb, lc;
    chk("lfsr_seq1", int'(lfsr_seq[1]), 32'hE270);
    chk("lfsr_seq2", int'(lfsr_seq[2]), 32'h7138);

    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_outs", int'({a, b, valid, busy, done}), 0);
    chk("reset_cnt", int'(pair_cnt), 0);
    @(posedge clk); #1;

    run_burst(4, 0, 0, 0, 0, vc, eqc, eqp, dc, vi, fa, fb, lc);
    chk("seed_first_a", fa, 1);
    chk("seed_first_b", fb, 0);

    run_burst(10, 1, 0, 0, 0, vc, eqc, eqp, dc, vi, fa, fb, lc);
    chk("m1_valid_cycles", vc, 10);
    chk("m1_done_cycle", dc, 11);
    chk("m1_pair_cnt", lc, 10);
    chk("m1_viol", vi, 0);

    run_burst(200, 2, 0, 0, 0, vc, eqc, eqp, dc, vi, fa, fb, lc);
    chk("m2_valid_cycles", vc, 200);
    chk("m2_viol", vi, 0);
    run_burst(200, 3, 0, 0, 0, vc, eqc, eqp, dc, vi, fa, fb, lc);
    chk("m3_viol", vi, 0);

    run_burst(8, 3, 3, 0, 0, vc, eqc, eqp, dc, vi, fa, fb, lc);
    chk("inj_count", eqc, 1);
    chk("inj_pos", eqp, 5);
    chk("inj_valid_cycles", vc, 8);

    run_burst(0, 1, 0, 0, 0, vc, eqc, eqp, dc, vi, fa, fb, lc);
    chk("n0_valid", vc, 0);
    chk("n0_done_cycle", dc, 1);
    chk("n0_pair_cnt", lc, 0);
    run_burst(6, 2, 0, 3, 0, vc, eqc, eqp, dc, vi, fa, fb, lc);
    chk("start_in_run_len", vc, 6);
    chk("start_in_run_done", dc, 7);

    run_burst(20, 0, 0, 0, 4, vc, eqc, eqp, dc, vi, fa, fb, lc);
    chk("rst_mid_valid", vc, 4);
    chk("rst_mid_no_done", dc, 0);
    run_burst(5, 0, 0, 0, 0, vc, eqc, eqp, dc, vi, fa, fb, lc);
    chk("post_rst_a", fa, 1);
    chk("post_rst_b", fb, 0);
    chk("post_rst_len", vc, 5);

    for (int k = 0; k < 40; k++) begin
      int n, m, inj, sa, ra;
      n   = int'($urandom_range(0, 24));
      m   = int'($urandom_range(0, 3));
      inj = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, n + 3));
      sa  = (n >= 2 && $urandom_range(0, 3) == 0) ? int'($urandom_range(2, n)) : 0;
      ra  = (n >= 1 && $urandom_range(0, 7) == 0) ? int'($urandom_range(1, n + 2)) : 0;
      run_burst(n, m, inj, sa, ra, vc, eqc, eqp, dc, vi, fa, fb, lc);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
